// File: rtl/vc_credit_mgr.sv
// Per-VC transmit credit manager: loads initial credits, tracks returns and
// consumes per virtual channel, and reports eligibility, stalls and credit errors.
module vc_credit_mgr #(
    parameter int NUM_VC      = 4,
    parameter int VC_W        = 2,
    parameter int CRED_W      = 8,
    parameter int MAX_CREDITS = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     init_load_i,
    input  logic                     flush_i,
    input  logic [NUM_VC*CRED_W-1:0] cfg_init_credit_i,
    input  logic [NUM_VC-1:0]        dec_credit_vc_i,
    input  logic                     crd_ret_valid_i,
    input  logic [VC_W-1:0]          crd_ret_vc_i,
    input  logic [CRED_W-1:0]        crd_ret_cnt_i,
    input  logic [NUM_VC-1:0]        vcq_valid_i,
    input  logic                     stat_clr_i,
    input  logic                     err_clr_i,
    output logic [NUM_VC-1:0]        vc_can_send_o,
    output logic [NUM_VC*CRED_W-1:0] credit_o,
    output logic                     active_o,
    output logic [31:0]              stat_credit_stall_o,
    output logic                     err_underflow_o,
    output logic                     err_overflow_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE} state_e;

    localparam logic [CRED_W:0] MAX_EXT = (CRED_W+1)'(MAX_CREDITS);

    state_e                          state_q, state_d;
    logic [NUM_VC-1:0][CRED_W-1:0]   cnt_q, cnt_d;
    logic [NUM_VC-1:0][CRED_W:0]     ret_ext, nxt_ext;
    logic [31:0]                     stall_q, stall_d;
    logic                            uf_q, uf_d, ov_q, ov_d;
    logic                            uf_set, ov_set, stall_evt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (init_load_i) state_d = S_LOAD;
            S_LOAD:   state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_ACTIVE;
            default:  state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    // Handshake: dec_credit_vc_i[v] and crd_ret_valid_i are single-cycle strobes with
    // no back-pressure; each set bit is acted on exactly once in the cycle it is high.
    always_comb begin
        cnt_d  = cnt_q;
        uf_set = 1'b0;
        ov_set = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            ret_ext[v] = (crd_ret_valid_i && crd_ret_vc_i == VC_W'(v)) ?
                         {1'b0, crd_ret_cnt_i} : '0;
            nxt_ext[v] = {1'b0, cnt_q[v]} + ret_ext[v] - (CRED_W+1)'(dec_credit_vc_i[v]);
        end
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                uf_set = |dec_credit_vc_i;
            end
            S_LOAD: begin
                uf_set = |dec_credit_vc_i;
                for (int v = 0; v < NUM_VC; v++) begin
                    if ({1'b0, cfg_init_credit_i[v*CRED_W +: CRED_W]} > MAX_EXT)
                        cnt_d[v] = MAX_EXT[CRED_W-1:0];
                    else
                        cnt_d[v] = cfg_init_credit_i[v*CRED_W +: CRED_W];
                end
            end
            S_ACTIVE: begin
                for (int v = 0; v < NUM_VC; v++) begin
                    // Underflow must be caught before the range check, since the
                    // (CRED_W+1)-bit difference wraps to a huge value.
                    if (cnt_q[v] == '0 && ret_ext[v] == '0 && dec_credit_vc_i[v]) begin
                        uf_set = 1'b1;
                    end else if (nxt_ext[v] > MAX_EXT) begin
                        cnt_d[v] = MAX_EXT[CRED_W-1:0];
                        ov_set   = 1'b1;
                    end else begin
                        cnt_d[v] = nxt_ext[v][CRED_W-1:0];
                    end
                end
            end
            default: cnt_d = '0;
        endcase
        if (flush_i) begin
            cnt_d  = '0;
            uf_set = 1'b0;
            ov_set = 1'b0;
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++)
            vc_can_send_o[v] = (state_q == S_ACTIVE) && (cnt_q[v] != '0);
        stall_evt = (state_q == S_ACTIVE) && |(vcq_valid_i & ~vc_can_send_o);
        stall_d   = stall_q;
        if (stat_clr_i)
            stall_d = '0;
        else if (stall_evt && stall_q != '1)
            stall_d = stall_q + 32'd1;
        uf_d = uf_set | (uf_q & ~err_clr_i);
        ov_d = ov_set | (ov_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stall_q <= '0;
            uf_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            uf_q    <= uf_d;
            ov_q    <= ov_d;
        end
    end

    assign credit_o            = cnt_q;
    assign active_o            = (state_q == S_ACTIVE);
    assign stat_credit_stall_o = stall_q;
    assign err_underflow_o     = uf_q;
    assign err_overflow_o      = ov_q;

endmodule
